// File: rtl/mbus_tx_if.sv
// Sequencer-to-transmitter handshake: microword, repeat count, valid/ready.
interface mbus_tx_if;
  logic [15:0] in_data;
  logic [3:0]  in_rep;
  logic        in_valid;
  logic        in_ready;

  // Sequencer side drives the word; transmitter answers with ready.
  modport master (output in_data, output in_rep, output in_valid, input in_ready);
  modport slave  (input in_data, input in_rep, input in_valid, output in_ready);
endinterface

// File: rtl/mbus_tx.sv
// Microinstruction bus transmitter: FIFO of microwords issued one per clock
// onto the multiplexed pin_m bus, with per-word repeat, stall (ALU Z-state)
// and IDLE_WORD insertion when starved. The bus is driven only in the low
// phase of pin_clk so the ALU can latch it on the rising edge.
module mbus_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] IDLE_WORD = 16'hFF00
) (
  input  logic        pin_clk,
  input  logic        pin_rst_n,
  mbus_tx_if.slave    seq,
  input  logic        pin_ez_n,
  output wire  [15:0] pin_m,
  output logic        m_act,
  output logic [4:0]  lvl
);

  localparam int unsigned AW = (DEPTH > 8) ? 4 : (DEPTH > 4) ? 3 : (DEPTH > 2) ? 2 : 1;
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_REPEAT = 2'd2,
    S_STALL  = 2'd3
  } state_t;

  state_t          state_r, state_n, saved_r, saved_n, eff_s;
  logic [15:0]     mem_data_r [DEPTH];
  logic [3:0]      mem_rep_r  [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [4:0]      lvl_r, lvl_n;
  logic            ready_r;
  logic [15:0]     cur_r, cur_n;
  logic [3:0]      rep_r, rep_n;
  logic            act_r, act_n;
  logic            push_s, pop_s, empty_s;

  assign push_s       = seq.in_valid & ready_r;
  assign empty_s      = (lvl_r == 5'd0);
  assign seq.in_ready = ready_r;
  assign m_act        = act_r;
  assign lvl          = lvl_r;

  // Bus is a pure level gate on the registered word; cur only moves at the rising edge.
  assign pin_m = (!pin_clk && pin_ez_n && pin_rst_n) ? cur_r : 16'hzzzz;

  // Next-state / issue logic; a release edge performs the saved state's action so nothing is lost.
  always_comb begin
    state_n = state_r;
    saved_n = saved_r;
    cur_n   = cur_r;
    rep_n   = rep_r;
    act_n   = act_r;
    pop_s   = 1'b0;
    if (state_r == S_STALL) begin
      eff_s = saved_r;
    end else begin
      eff_s = state_r;
    end
    if (!pin_ez_n) begin
      saved_n = eff_s;
      state_n = S_STALL;
    end else begin
      case (eff_s)
        S_REPEAT: begin
          rep_n = rep_r - 4'd1;
          if (rep_r == 4'd1) begin
            state_n = S_ISSUE;
          end else begin
            state_n = S_REPEAT;
          end
        end
        S_IDLE, S_ISSUE: begin
          if (!empty_s) begin
            pop_s = 1'b1;
            cur_n = mem_data_r[rd_ptr_r];
            rep_n = mem_rep_r[rd_ptr_r];
            act_n = 1'b1;
            if (mem_rep_r[rd_ptr_r] != 4'd0) begin
              state_n = S_REPEAT;
            end else begin
              state_n = S_ISSUE;
            end
          end else begin
            cur_n   = IDLE_WORD;
            rep_n   = 4'd0;
            act_n   = 1'b0;
            state_n = S_IDLE;
          end
        end
        default: begin
          cur_n   = IDLE_WORD;
          rep_n   = 4'd0;
          act_n   = 1'b0;
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // Occupancy after this edge's push/pop; simultaneous push and pop cancel.
  always_comb begin
    if (push_s && !pop_s) begin
      lvl_n = lvl_r + 5'd1;
    end else if (pop_s && !push_s) begin
      lvl_n = lvl_r - 5'd1;
    end else begin
      lvl_n = lvl_r;
    end
  end

  // Sequencer state, issued word, repeat counter, occupancy and ready.
  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      state_r  <= S_IDLE;
      saved_r  <= S_IDLE;
      cur_r    <= IDLE_WORD;
      rep_r    <= 4'd0;
      act_r    <= 1'b0;
      lvl_r    <= 5'd0;
      ready_r  <= 1'b0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      state_r <= state_n;
      saved_r <= saved_n;
      cur_r   <= cur_n;
      rep_r   <= rep_n;
      act_r   <= act_n;
      lvl_r   <= lvl_n;
      ready_r <= (lvl_n < DEPTH_L);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage, written at the tail on every accepted push.
  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data_r[i] <= 16'h0000;
        mem_rep_r[i]  <= 4'd0;
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= seq.in_data;
      mem_rep_r[wr_ptr_r]  <= seq.in_rep;
    end
  end

endmodule
